read_src_fsm: RTL and testbench

Source-side read engine of the DMA data path. On a go descriptor it issues one AXI read burst to the source memory, accepts the returning R beats and pushes each beat into the shared data FIFO, which the destination write engine drains. Sits between the descriptor FIFO/CSR block and the PIM `ofs_plat_axi_mem_if` source port; reports state, errors and performance counters into the CSR status.

---
 rtl/dma_pkg.sv | 60 ++++++
 rtl/dma_perf_cntr.sv | 30 +++
 rtl/read_src_fsm.sv | 186 ++++++++++++++++++
 tb/tb_read_src_fsm.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA data path.
//   - descriptor / CSR control / CSR status records used by the read engine
//   - AXI address-channel payload record and response/burst encodings
//   - one-hot state constants of the source read engine
package dma_pkg;

    localparam int ADDR_W      = 64;
    localparam int LENGTH_W    = 16;
    localparam int PERF_CNTR_W = 32;
    localparam int AXI_ID_W    = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Read engine states, one-hot; the vector itself is reported as rd_state.
    localparam logic [3:0] ST_IDLE           = 4'b0001;
    localparam logic [3:0] ST_ADDR_SETUP     = 4'b0010;
    localparam logic [3:0] ST_RD_SRC_WR_FIFO = 4'b0100;
    localparam logic [3:0] ST_ERROR          = 4'b1000;

    typedef struct packed {
        logic go;
    } t_dma_descriptor_control;

    typedef struct packed {
        logic [ADDR_W-1:0]       src_addr;
        logic [LENGTH_W-1:0]     length;      // in beats
        t_dma_descriptor_control descriptor_control;
    } t_dma_descriptor;

    typedef struct packed {
        logic reset_dispatcher;
    } t_dma_csr_control;

    typedef struct packed {
        logic [3:0]             rd_state;
        logic                   busy;
        logic                   rd_rsp_err;
        logic                   stopped_on_error;
        logic [PERF_CNTR_W-1:0] rd_src_clk_cnt;
        logic [PERF_CNTR_W-1:0] rd_src_valid_cnt;
    } t_dma_csr_status;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [ADDR_W-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } t_axi_ax;

    // SLVERR and DECERR both have the upper response bit set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/dma_perf_cntr.sv
// dma_perf_cntr: saturating performance counter shared by the DMA engines.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear (wins over enable)
//   en           : count one per enabled cycle, sticking at all-ones
//   cnt          : current count
module dma_perf_cntr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/read_src_fsm.sv
// read_src_fsm: source-side read engine of the DMA data path.
// On a go descriptor it issues one AXI INCR read burst and streams every
// returned R beat straight into the shared data FIFO.
//   descriptor / descriptor_fifo_not_empty : next transfer request
//   csr_control.reset_dispatcher           : leaves ERROR
//   rd_fsm_done                            : one-cycle pulse per clean burst
//   rd_src_status                          : state, flags, perf counters
//   src_mem_*                              : AXI source port (AR/R used, AW/W/B tied off)
//   wr_fifo_*                              : data FIFO write side
module read_src_fsm
    import dma_pkg::*;
#(
    parameter int DATA_W = 512
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   descriptor_fifo_not_empty,
    input  t_dma_descriptor        descriptor,
    input  t_dma_csr_control       csr_control,
    output logic                   rd_fsm_done,
    output t_dma_csr_status        rd_src_status,
    output logic                   src_mem_arvalid,
    input  logic                   src_mem_arready,
    output t_axi_ax                src_mem_ar,
    input  logic                   src_mem_rvalid,
    output logic                   src_mem_rready,
    input  logic [DATA_W-1:0]      src_mem_rdata,
    input  logic [1:0]             src_mem_rresp,
    input  logic                   src_mem_rlast,
    input  logic [AXI_ID_W-1:0]    src_mem_rid,
    output logic                   src_mem_awvalid,
    input  logic                   src_mem_awready,
    output t_axi_ax                src_mem_aw,
    output logic                   src_mem_wvalid,
    input  logic                   src_mem_wready,
    output logic [DATA_W-1:0]      src_mem_wdata,
    output logic [DATA_W/8-1:0]    src_mem_wstrb,
    output logic                   src_mem_wlast,
    input  logic                   src_mem_bvalid,
    output logic                   src_mem_bready,
    input  logic [1:0]             src_mem_bresp,
    input  logic [AXI_ID_W-1:0]    src_mem_bid,
    output logic                   wr_fifo_wr_en,
    output logic [DATA_W-1:0]      wr_fifo_wr_data,
    input  logic                   wr_fifo_almost_full
);

    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W/8));

    logic [3:0]             state, state_nxt;
    logic [LENGTH_W-1:0]    length_q, beat_cnt;
    logic                   rd_rsp_err_q;
    logic                   go_seen, enter_addr, beat_acc, beat_is_final;
    logic [PERF_CNTR_W-1:0] clk_cnt, valid_cnt;
    logic                   unused_inputs;

    assign go_seen       = descriptor.descriptor_control.go & descriptor_fifo_not_empty;
    assign enter_addr    = (state == ST_IDLE) && (state_nxt == ST_ADDR_SETUP);
    assign beat_acc      = src_mem_rvalid & src_mem_rready;
    assign beat_is_final = (beat_cnt == length_q - LENGTH_W'(1));

    // ERROR keeps rready high so stray beats of an aborted burst drain away.
    always_comb begin
        src_mem_rready = 1'b0;
        case (state)
            ST_RD_SRC_WR_FIFO: src_mem_rready = !wr_fifo_almost_full;
            ST_ERROR:          src_mem_rready = 1'b1;
            default:           src_mem_rready = 1'b0;
        endcase
    end

    // Zero-latency R -> FIFO path; drained beats in ERROR are not written.
    assign wr_fifo_wr_en   = beat_acc && (state == ST_RD_SRC_WR_FIFO);
    assign wr_fifo_wr_data = src_mem_rdata;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (go_seen) begin
                    state_nxt = (descriptor.length != '0) ? ST_ADDR_SETUP : ST_ERROR;
                end
            end
            ST_ADDR_SETUP: begin
                if (src_mem_arvalid && src_mem_arready) begin
                    state_nxt = ST_RD_SRC_WR_FIFO;
                end
            end
            ST_RD_SRC_WR_FIFO: begin
                if (beat_acc) begin
                    if (resp_is_err(src_mem_rresp)) begin
                        state_nxt = ST_ERROR;
                    end else if (src_mem_rlast && beat_is_final) begin
                        state_nxt = ST_IDLE;
                    end else if (src_mem_rlast || beat_is_final) begin
                        // Burst length disagrees with the descriptor.
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                if (csr_control.reset_dispatcher) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            src_mem_arvalid <= 1'b0;
            src_mem_ar      <= '0;
            length_q        <= '0;
            beat_cnt        <= '0;
            rd_rsp_err_q    <= 1'b0;
            rd_fsm_done     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_fsm_done <= (state == ST_RD_SRC_WR_FIFO) && (state_nxt == ST_IDLE);

            // AR payload is loaded once and held until the handshake.
            if (enter_addr) begin
                src_mem_arvalid  <= 1'b1;
                src_mem_ar.id    <= '0;
                src_mem_ar.addr  <= descriptor.src_addr;
                src_mem_ar.len   <= 8'(descriptor.length - LENGTH_W'(1));
                src_mem_ar.size  <= AR_SIZE;
                src_mem_ar.burst <= BURST_INCR;
                length_q         <= descriptor.length;
            end else if (src_mem_arvalid && src_mem_arready) begin
                src_mem_arvalid <= 1'b0;
            end

            if (enter_addr) begin
                beat_cnt <= '0;
            end else if (wr_fifo_wr_en) begin
                beat_cnt <= beat_cnt + LENGTH_W'(1);
            end

            // A zero-length descriptor enters ERROR without a response error.
            if ((state == ST_RD_SRC_WR_FIFO) && (state_nxt == ST_ERROR)) begin
                rd_rsp_err_q <= 1'b1;
            end else if ((state == ST_ERROR) && (state_nxt == ST_IDLE)) begin
                rd_rsp_err_q <= 1'b0;
            end
        end
    end

    dma_perf_cntr #(.W(PERF_CNTR_W)) u_clk_cntr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (enter_addr),
        .en      (state == ST_RD_SRC_WR_FIFO),
        .cnt     (clk_cnt)
    );

    dma_perf_cntr #(.W(PERF_CNTR_W)) u_valid_cntr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (enter_addr),
        .en      (wr_fifo_wr_en),
        .cnt     (valid_cnt)
    );

    assign rd_src_status.rd_state         = state;
    assign rd_src_status.busy             = (state == ST_ADDR_SETUP) || (state == ST_RD_SRC_WR_FIFO);
    assign rd_src_status.rd_rsp_err       = rd_rsp_err_q;
    assign rd_src_status.stopped_on_error = (state == ST_ERROR);
    assign rd_src_status.rd_src_clk_cnt   = clk_cnt;
    assign rd_src_status.rd_src_valid_cnt = valid_cnt;

    // Write side of the source port is never used by this engine.
    assign src_mem_awvalid = 1'b0;
    assign src_mem_aw      = '0;
    assign src_mem_wvalid  = 1'b0;
    assign src_mem_wdata   = '0;
    assign src_mem_wstrb   = '0;
    assign src_mem_wlast   = 1'b0;
    assign src_mem_bready  = 1'b1;

    assign unused_inputs = &{1'b0, src_mem_rid, src_mem_awready, src_mem_wready,
                             src_mem_bvalid, src_mem_bresp, src_mem_bid};

endmodule

// File: tb/tb_read_src_fsm.sv
// tb_read_src_fsm: directed bench for read_src_fsm. A per-cycle vector table
// covers clean, SLVERR, early-last, zero-length and missing-last bursts;
// hand sequences cover almost_full throttling, AR back-pressure and reset
// in the middle of a burst.
module tb_read_src_fsm;
    import dma_pkg::*;

    localparam int DATA_W = 512;
    localparam logic [3:0] SI = ST_IDLE;
    localparam logic [3:0] SA = ST_ADDR_SETUP;
    localparam logic [3:0] SR = ST_RD_SRC_WR_FIFO;
    localparam logic [3:0] SE = ST_ERROR;

    logic                clk;
    logic                reset_n;
    logic                not_empty;
    t_dma_descriptor     descriptor;
    t_dma_csr_control    csr_control;
    logic                rd_fsm_done;
    t_dma_csr_status     st;
    logic                arvalid, arready;
    t_axi_ax             ar, aw;
    logic                rvalid, rready, rlast;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                awvalid, wvalid, wlast, bready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wr_en, afull;
    logic [DATA_W-1:0]   wr_data;

    read_src_fsm #(.DATA_W(DATA_W)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .descriptor_fifo_not_empty (not_empty),
        .descriptor                (descriptor),
        .csr_control               (csr_control),
        .rd_fsm_done               (rd_fsm_done),
        .rd_src_status             (st),
        .src_mem_arvalid           (arvalid),
        .src_mem_arready           (arready),
        .src_mem_ar                (ar),
        .src_mem_rvalid            (rvalid),
        .src_mem_rready            (rready),
        .src_mem_rdata             (rdata),
        .src_mem_rresp             (rresp),
        .src_mem_rlast             (rlast),
        .src_mem_rid               ('0),
        .src_mem_awvalid           (awvalid),
        .src_mem_awready           (1'b1),
        .src_mem_aw                (aw),
        .src_mem_wvalid            (wvalid),
        .src_mem_wready            (1'b1),
        .src_mem_wdata             (wdata),
        .src_mem_wstrb             (wstrb),
        .src_mem_wlast             (wlast),
        .src_mem_bvalid            (1'b0),
        .src_mem_bready            (bready),
        .src_mem_bresp             (2'b00),
        .src_mem_bid               ('0),
        .wr_fifo_wr_en             (wr_en),
        .wr_fifo_wr_data           (wr_data),
        .wr_fifo_almost_full       (afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        go;
        logic [15:0] len;
        logic [63:0] addr;
        logic        rv;
        logic [7:0]  d;
        logic [1:0]  resp;
        logic        last;
        logic        rdisp;
        logic [3:0]  e_state;
        logic        e_arv;
        logic        e_rr;
        logic        e_we;
        logic        e_done;
        logic        e_err;
        int          e_ccnt;
        int          e_vcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(logic go, logic [15:0] len, logic [63:0] addr,
                                 logic rv, logic [7:0] d, logic [1:0] resp, logic last, logic rdisp,
                                 logic [3:0] es, logic earv, logic err_rr, logic ewe, logic edone,
                                 logic eerr, int eccnt, int evcnt);
        vec_t v;
        v.go = go; v.len = len; v.addr = addr; v.rv = rv; v.d = d; v.resp = resp;
        v.last = last; v.rdisp = rdisp; v.e_state = es; v.e_arv = earv; v.e_rr = err_rr;
        v.e_we = ewe; v.e_done = edone; v.e_err = eerr; v.e_ccnt = eccnt; v.e_vcnt = evcnt;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] wide(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        descriptor  = '0;
        not_empty   = 1'b0;
        csr_control = '0;
        arready     = 1'b1;
        rvalid      = 1'b0;
        rdata       = '0;
        rresp       = RESP_OKAY;
        rlast       = 1'b0;
        afull       = 1'b0;
    endtask

    task automatic start_desc(input logic [15:0] len, input logic [63:0] addr);
        descriptor.src_addr = addr;
        descriptor.length   = len;
        descriptor.descriptor_control.go = 1'b1;
        not_empty = 1'b1;
    endtask

    logic [63:0] cur_addr;
    logic [15:0] cur_len;

    initial begin
        reset_n = 1'b0;
        drive_idle();
        cur_addr = '0;
        cur_len  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.state", st.rd_state, SI);
        chk("rst.arvalid", arvalid, 0);
        chk("rst.ar", ar, '0);
        chk("rst.busy", st.busy, 0);
        chk("rst.done", rd_fsm_done, 0);
        chk("rst.rsp_err", st.rd_rsp_err, 0);
        chk("rst.stopped", st.stopped_on_error, 0);
        chk("rst.clk_cnt", st.rd_src_clk_cnt, 0);
        chk("rst.valid_cnt", st.rd_src_valid_cnt, 0);
        chk("rst.rready", rready, 0);
        chk("rst.wr_en", wr_en, 0);
        chk("rst.tieoff", {awvalid, wvalid, wlast, bready}, 4'b0001);
        chk("rst.aw", aw, '0);
        step();
        reset_n = 1'b1;

        // go len addr | rv d resp last rdisp | state arv rr we done err ccnt vcnt
        // clean length-4 burst
        vecs.push_back(row(1, 4, 'h1000, 0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SA, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hA0, 0, 0, 0, SR, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hA1, 0, 0, 0, SR, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(row(0, 0, 0,      1, 8'hA2, 0, 0, 0, SR, 0, 1, 1, 0, 0, 2, 2));
        vecs.push_back(row(0, 0, 0,      1, 8'hA3, 0, 1, 0, SR, 0, 1, 1, 0, 0, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 1, 0, 4, 4));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 4, 4));
        // SLVERR on the third beat, then a stray beat drained in ERROR
        vecs.push_back(row(1, 4, 'h2000, 0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 4, 4));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SA, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hB0, 0, 0, 0, SR, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hB1, 0, 0, 0, SR, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(row(0, 0, 0,      1, 8'hB2, 2, 0, 0, SR, 0, 1, 1, 0, 0, 2, 2));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SE, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(row(0, 0, 0,      1, 8'h55, 0, 0, 0, SE, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 1, SE, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 3, 3));
        // r.last on the third beat of a 4-beat burst
        vecs.push_back(row(1, 4, 'h3000, 0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SA, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hC0, 0, 0, 0, SR, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hC1, 0, 0, 0, SR, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(row(0, 0, 0,      1, 8'hC2, 0, 1, 0, SR, 0, 1, 1, 0, 0, 2, 2));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SE, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 1, SE, 0, 1, 0, 0, 1, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 3, 3));
        // zero-length descriptor: straight to ERROR, no AR, no response error
        vecs.push_back(row(1, 0, 'h4000, 0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SE, 0, 1, 0, 0, 0, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 1, SE, 0, 1, 0, 0, 0, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 3, 3));
        // final beat of a 2-beat burst arrives without r.last
        vecs.push_back(row(1, 2, 'h5000, 0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SA, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hE0, 0, 0, 0, SR, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(row(0, 0, 0,      1, 8'hE1, 0, 0, 0, SR, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SE, 0, 1, 0, 0, 1, 2, 2));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 1, SE, 0, 1, 0, 0, 1, 2, 2));
        vecs.push_back(row(0, 0, 0,      0, 8'h00, 0, 0, 0, SI, 0, 0, 0, 0, 0, 2, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            descriptor.src_addr = vecs[i].addr;
            descriptor.length   = vecs[i].len;
            descriptor.descriptor_control.go = vecs[i].go;
            not_empty = vecs[i].go;
            csr_control.reset_dispatcher = vecs[i].rdisp;
            rvalid = vecs[i].rv;
            rdata  = wide(vecs[i].d);
            rresp  = vecs[i].resp;
            rlast  = vecs[i].last;
            if (vecs[i].go) begin
                cur_addr = vecs[i].addr;
                cur_len  = vecs[i].len;
            end
            @(negedge clk);
            chk($sformatf("r%0d.state", i), st.rd_state, vecs[i].e_state);
            chk($sformatf("r%0d.arvalid", i), arvalid, vecs[i].e_arv);
            chk($sformatf("r%0d.rready", i), rready, vecs[i].e_rr);
            chk($sformatf("r%0d.wr_en", i), wr_en, vecs[i].e_we);
            chk($sformatf("r%0d.done", i), rd_fsm_done, vecs[i].e_done);
            chk($sformatf("r%0d.rsp_err", i), st.rd_rsp_err, vecs[i].e_err);
            chk($sformatf("r%0d.busy", i), st.busy,
                (vecs[i].e_state == SA) || (vecs[i].e_state == SR));
            chk($sformatf("r%0d.stopped", i), st.stopped_on_error, vecs[i].e_state == SE);
            chk($sformatf("r%0d.clk_cnt", i), st.rd_src_clk_cnt, vecs[i].e_ccnt);
            chk($sformatf("r%0d.valid_cnt", i), st.rd_src_valid_cnt, vecs[i].e_vcnt);
            if (vecs[i].e_we) chk($sformatf("r%0d.wr_data", i), wr_data, wide(vecs[i].d));
            if (vecs[i].e_arv) begin
                chk($sformatf("r%0d.ar.addr", i), ar.addr, cur_addr);
                chk($sformatf("r%0d.ar.len", i), ar.len, 8'(cur_len - 16'd1));
                chk($sformatf("r%0d.ar.size", i), ar.size, 3'd6);
                chk($sformatf("r%0d.ar.burst", i), ar.burst, 2'b01);
                chk($sformatf("r%0d.ar.id", i), ar.id, 0);
            end
            step();
        end
        drive_idle();

        // length 8 with almost_full toggling every two cycles
        begin
            int acc = 0;
            int k   = 0;
            start_desc(16'd8, 64'h6000);
            step();
            drive_idle();
            step();
            while (acc < 8 && k < 40) begin
                afull  = ((k / 2) % 2) == 1;
                rvalid = 1'b1;
                rdata  = wide(8'(8'h80 + acc));
                rlast  = (acc == 7);
                @(negedge clk);
                chk("af.rready", rready, !afull);
                chk("af.wr_en", wr_en, !afull);
                if (!afull) begin
                    chk("af.wr_data", wr_data, wide(8'(8'h80 + acc)));
                    acc++;
                end
                k++;
                step();
            end
            if (acc < 8) chk("af.timeout", acc, 8);
            drive_idle();
            @(negedge clk);
            chk("af.done", rd_fsm_done, 1);
            chk("af.valid_cnt", st.rd_src_valid_cnt, 8);
            chk("af.clk_cnt", st.rd_src_clk_cnt, k);
            step();
        end

        // arready held low for 10 cycles
        start_desc(16'd4, 64'h7000_0040);
        arready = 1'b0;
        step();
        descriptor = '0;
        not_empty  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("arhold.arvalid", arvalid, 1);
            chk("arhold.addr", ar.addr, 64'h7000_0040);
            chk("arhold.len", ar.len, 3);
            chk("arhold.state", st.rd_state, SA);
            step();
        end
        arready = 1'b1;
        @(negedge clk);
        chk("arhold.arvalid_last", arvalid, 1);
        step();
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rdata  = wide(8'(8'hD0 + b));
            rlast  = (b == 3);
            @(negedge clk);
            chk("arhold.wr_en", wr_en, 1);
            chk("arhold.wr_data", wr_data, wide(8'(8'hD0 + b)));
            step();
        end
        drive_idle();
        @(negedge clk);
        chk("arhold.done", rd_fsm_done, 1);
        step();

        // reset asserted while the third beat is on the bus
        start_desc(16'd4, 64'h8000);
        step();
        drive_idle();
        step();
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1;
            rdata  = wide(8'(8'hF0 + b));
            @(negedge clk);
            chk("mid.wr_en", wr_en, 1);
            step();
        end
        rvalid = 1'b1;
        rdata  = wide(8'hF2);
        #1;
        chk("mid.pre_wr_en", wr_en, 1);
        reset_n = 1'b0;
        #1;
        chk("mid.wr_en_rst", wr_en, 0);
        chk("mid.rready_rst", rready, 0);
        chk("mid.arvalid_rst", arvalid, 0);
        chk("mid.busy_rst", st.busy, 0);
        chk("mid.state_rst", st.rd_state, SI);
        chk("mid.valid_cnt_rst", st.rd_src_valid_cnt, 0);
        rvalid = 1'b0;
        step();
        reset_n = 1'b1;
        start_desc(16'd2, 64'h9000);
        step();
        drive_idle();
        @(negedge clk);
        chk("mid.re_arvalid", arvalid, 1);
        chk("mid.re_addr", ar.addr, 64'h9000);
        chk("mid.re_len", ar.len, 1);
        step();
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1;
            rdata  = wide(8'(8'h90 + b));
            rlast  = (b == 1);
            @(negedge clk);
            chk("mid.re_wr_en", wr_en, 1);
            chk("mid.re_wr_data", wr_data, wide(8'(8'h90 + b)));
            step();
        end
        drive_idle();
        @(negedge clk);
        chk("mid.re_done", rd_fsm_done, 1);
        chk("mid.re_rsp_err", st.rd_rsp_err, 0);
        chk("mid.re_valid_cnt", st.rd_src_valid_cnt, 2);
        step();
        @(negedge clk);
        chk("mid.re_done_once", rd_fsm_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
